// File: rtl/odo_sched_pkg.sv
// Shared types and widths for the odo work scheduler and its found-nonce FIFO.
package odo_sched_pkg;

   localparam int unsigned NONCE_W  = 32;
   localparam int unsigned HEADER_W = 608;
   localparam int unsigned TARGET_W = 256;
   localparam int unsigned PIPE_W   = NONCE_W + HEADER_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sched_state_t;

   // Word presented to the hashing pipeline; nonce occupies the upper bits.
   typedef struct packed {
      logic [NONCE_W-1:0]  nonce;
      logic [HEADER_W-1:0] header;
   } pipe_word_t;

   function automatic logic [NONCE_W-1:0] nonce_inc(input logic [NONCE_W-1:0] n);
      return n + NONCE_W'(1);
   endfunction

endpackage

// File: rtl/found_fifo.sv
// Small synchronous FIFO holding winning nonces; head, full and empty are registered.
module found_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [CNT_W-1:0] count, count_n;
   logic             push_ok, pop_ok;
   logic [WIDTH-1:0] head_n;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A pop while full frees the slot for a same-cycle push.
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_n = push_ok ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr_n = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
      count_n  = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      head_n   = (push_ok && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) mem[wr_ptr] <= din;
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         head   <= head_n;
         full   <= (count_n == CNT_W'(DEPTH));
         empty  <= (count_n == '0);
      end
   end

endmodule

// File: rtl/odo_work_sched.sv
// Work scheduler: paces nonce issue into the hashing pipeline, tracks work epochs
// so stale results are dropped, and queues winning nonces for the host.
module odo_work_sched
   import odo_sched_pkg::*;
#(
   parameter int unsigned THROUGHPUT   = 8,
   parameter int unsigned MAX_INFLIGHT = 255,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                work_load,
   input  logic [HEADER_W-1:0] work_header,
   input  logic [TARGET_W-1:0] work_target,
   input  logic [NONCE_W-1:0]  work_nonce,
   output logic [PIPE_W-1:0]   pipe_in,
   output logic                pipe_read,
   output logic [TARGET_W-1:0] pipe_target,
   input  logic                pipe_res,
   input  logic                pipe_write,
   output logic                found_valid,
   output logic [NONCE_W-1:0]  found_nonce,
   input  logic                found_ready,
   output logic                found_overflow,
   output logic                busy,
   output logic                exhausted
);

   localparam int unsigned SLOT_W = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;
   localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT + 1);
   localparam logic [NONCE_W-1:0] NONCE_LAST = '1;

   sched_state_t        state, state_n;
   logic [SLOT_W-1:0]   slot, slot_n;
   logic [CNT_W-1:0]    outstanding, outstanding_n;
   logic [CNT_W-1:0]    discard, discard_n;
   logic [NONCE_W-1:0]  issue_nonce, issue_nonce_n;
   logic [NONCE_W-1:0]  ret_nonce, ret_nonce_n;
   logic [HEADER_W-1:0] header, header_n;
   pipe_word_t          word_n;
   logic                overflow_n;
   logic                write_ok_c, push_c, pop_c, drop_c;
   logic                issue_d_c, busy_d_c, exhausted_d_c;
   logic                fifo_full, fifo_empty;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         slot  <= '0;
      end else begin
         state <= state_n;
         slot  <= slot_n;
      end
   end

   // Next state; slot 0 is held while the in-flight limit blocks an issue.
   always_comb begin
      state_n = state;
      slot_n  = slot;
      if (work_load) begin
         state_n = ST_RUN;
         slot_n  = '0;
      end else if (state == ST_RUN) begin
         if (pipe_read && (issue_nonce == NONCE_LAST)) begin
            state_n = ST_DONE;
            slot_n  = '0;
         end else if ((slot == '0) && !pipe_read) begin
            slot_n = '0;
         end else if (slot == SLOT_W'(THROUGHPUT - 1)) begin
            slot_n = '0;
         end else begin
            slot_n = slot + SLOT_W'(1);
         end
      end else begin
         slot_n = '0;
      end
   end

   // Outputs are decided one cycle ahead so the issue strobe is a flop.
   always_comb begin
      issue_d_c     = (state_n == ST_RUN) && (slot_n == '0) &&
                      (outstanding_n < CNT_W'(MAX_INFLIGHT));
      busy_d_c      = (state_n == ST_RUN);
      exhausted_d_c = (state_n == ST_DONE);
   end

   // In-flight accounting, epoch discard and result nonce tracking.
   always_comb begin
      write_ok_c    = pipe_write && (outstanding != '0);
      outstanding_n = outstanding + CNT_W'(pipe_read) - CNT_W'(write_ok_c);
      discard_n     = discard;
      ret_nonce_n   = ret_nonce;
      push_c        = 1'b0;
      if (work_load) begin
         discard_n   = outstanding_n;
         ret_nonce_n = work_nonce;
      end else if (write_ok_c) begin
         if (discard != '0) begin
            discard_n = discard - CNT_W'(1);
         end else begin
            push_c      = pipe_res;
            ret_nonce_n = nonce_inc(ret_nonce);
         end
      end
      pop_c         = found_ready && found_valid;
      drop_c        = push_c && fifo_full && !pop_c;
      overflow_n    = work_load ? 1'b0 : (found_overflow || drop_c);
      issue_nonce_n = work_load ? work_nonce :
                      (pipe_read ? nonce_inc(issue_nonce) : issue_nonce);
      header_n      = work_load ? work_header : header;
      word_n.nonce  = issue_nonce_n;
      word_n.header = header_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding    <= '0;
         discard        <= '0;
         issue_nonce    <= '0;
         ret_nonce      <= '0;
         header         <= '0;
         found_overflow <= 1'b0;
      end else begin
         outstanding    <= outstanding_n;
         discard        <= discard_n;
         issue_nonce    <= issue_nonce_n;
         ret_nonce      <= ret_nonce_n;
         header         <= header_n;
         found_overflow <= overflow_n;
      end
   end

   // Pipeline-facing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_read   <= 1'b0;
         pipe_in     <= '0;
         pipe_target <= '0;
         busy        <= 1'b0;
         exhausted   <= 1'b0;
      end else begin
         pipe_read <= issue_d_c;
         busy      <= busy_d_c;
         exhausted <= exhausted_d_c;
         if (issue_d_c) pipe_in <= word_n;
         if (work_load) pipe_target <= work_target;
      end
   end

   found_fifo #(
      .WIDTH (NONCE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_found_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .din   (ret_nonce),
      .pop   (pop_c),
      .head  (found_nonce),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign found_valid = !fifo_empty;

endmodule

// File: tb/tb_odo_work_sched.sv
// Directed bench for odo_work_sched: a vector table for basic issue/return plus
// hand sequences for epoch switch, in-flight limit, exhaustion, overflow and reset.
`timescale 1ns/1ps
module tb_odo_work_sched;
   import odo_sched_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                work_load = 1'b0;
   logic [HEADER_W-1:0] work_header = {19{32'h1234_5678}};
   logic [TARGET_W-1:0] work_target = {8{32'hDEAD_BEEF}};
   logic [NONCE_W-1:0]  work_nonce = '0;

   logic [PIPE_W-1:0]   pipe_in;
   logic                pipe_read;
   logic [TARGET_W-1:0] pipe_target;
   logic                pipe_res = 1'b0, pipe_write = 1'b0;
   logic                found_valid, found_ready = 1'b0, found_overflow, busy, exhausted;
   logic [NONCE_W-1:0]  found_nonce;

   logic [PIPE_W-1:0]   l_pipe_in;
   logic                l_pipe_read;
   logic [TARGET_W-1:0] l_pipe_target;
   logic                l_pipe_res = 1'b0, l_pipe_write = 1'b0;
   logic                l_found_valid, l_found_ready = 1'b0, l_found_overflow, l_busy, l_exhausted;
   logic [NONCE_W-1:0]  l_found_nonce;

   always #5 clk = ~clk;

   odo_work_sched #(.THROUGHPUT(4), .MAX_INFLIGHT(255), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .work_load(work_load), .work_header(work_header),
      .work_target(work_target), .work_nonce(work_nonce), .pipe_in(pipe_in),
      .pipe_read(pipe_read), .pipe_target(pipe_target), .pipe_res(pipe_res),
      .pipe_write(pipe_write), .found_valid(found_valid), .found_nonce(found_nonce),
      .found_ready(found_ready), .found_overflow(found_overflow), .busy(busy),
      .exhausted(exhausted));

   odo_work_sched #(.THROUGHPUT(4), .MAX_INFLIGHT(2), .FIFO_DEPTH(4)) u_lim (
      .clk(clk), .rst_n(rst_n), .work_load(work_load), .work_header(work_header),
      .work_target(work_target), .work_nonce(work_nonce), .pipe_in(l_pipe_in),
      .pipe_read(l_pipe_read), .pipe_target(l_pipe_target), .pipe_res(l_pipe_res),
      .pipe_write(l_pipe_write), .found_valid(l_found_valid), .found_nonce(l_found_nonce),
      .found_ready(l_found_ready), .found_overflow(l_found_overflow), .busy(l_busy),
      .exhausted(l_exhausted));

   typedef struct {
      logic        ld;
      logic [31:0] nonce;
      logic        wr;
      logic        res;
      logic        rdy;
      logic        pr;
      logic [31:0] pn;
      logic        fv;
      logic [31:0] fn;
      logic        bz;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   int cnt;
   vec_t vecs [14];

   function automatic vec_t mk(input logic ld, input logic [31:0] n, input logic wr,
                               input logic res, input logic rdy, input logic pr,
                               input logic [31:0] pn, input logic fv, input logic [31:0] fn,
                               input logic bz);
      vec_t v;
      v.ld = ld; v.nonce = n; v.wr = wr; v.res = res; v.rdy = rdy;
      v.pr = pr; v.pn = pn; v.fv = fv; v.fn = fn; v.bz = bz;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic ld, input logic [31:0] n, input logic wr,
                         input logic res, input logic rdy);
      work_load = ld; work_nonce = n; pipe_write = wr; pipe_res = res; found_ready = rdy;
   endtask

   task automatic do_reset();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      l_pipe_write = 1'b0;
      l_pipe_res   = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [31:0] pin_nonce(input logic [PIPE_W-1:0] w);
      return w[PIPE_W-1 -: NONCE_W];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_pipe_read", 64'(pipe_read), 64'h0);
      check("rst_found_valid", 64'(found_valid), 64'h0);
      check("rst_overflow", 64'(found_overflow), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_exhausted", 64'(exhausted), 64'h0);
      check("rst_pipe_in_zero", 64'(pipe_in == '0), 64'h1);
      check("rst_target_zero", 64'(pipe_target == '0), 64'h1);
      check("rst_found_nonce", 64'(found_nonce), 64'h0);

      // Basic issue, THROUGHPUT=4, second result wins
      do_reset();
      vecs[0]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0);
      vecs[1]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0,  1'b1);
      vecs[2]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0,  1'b1);
      vecs[3]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0,  1'b1);
      vecs[4]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0,  1'b1);
      vecs[5]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 32'h0,  1'b1);
      vecs[6]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 1'b0, 32'h0,  1'b1);
      vecs[7]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 1'b0, 32'h0,  1'b1);
      vecs[8]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 1'b1, 32'h11, 1'b1);
      vecs[9]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h12, 1'b1, 32'h11, 1'b1);
      vecs[10] = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h12, 1'b0, 32'h0,  1'b1);
      vecs[11] = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h12, 1'b0, 32'h0,  1'b1);
      vecs[12] = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h12, 1'b0, 32'h0,  1'b1);
      vecs[13] = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 32'h0,  1'b1);
      for (int i = 0; i < 14; i++) begin
         set_in(vecs[i].ld, vecs[i].nonce, vecs[i].wr, vecs[i].res, vecs[i].rdy);
         check($sformatf("vec%0d_pipe_read", i), 64'(pipe_read), 64'(vecs[i].pr));
         check($sformatf("vec%0d_nonce", i), 64'(pin_nonce(pipe_in)), 64'(vecs[i].pn));
         check($sformatf("vec%0d_found_valid", i), 64'(found_valid), 64'(vecs[i].fv));
         check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].bz));
         if (vecs[i].fv)
            check($sformatf("vec%0d_found_nonce", i), 64'(found_nonce), 64'(vecs[i].fn));
         tick();
      end
      check("basic_target", 64'(pipe_target == {8{32'hDEAD_BEEF}}), 64'h1);
      check("basic_header", 64'(pipe_in[HEADER_W-1:0] == {19{32'h1234_5678}}), 64'h1);

      // Work switch with 3 outstanding
      do_reset();
      set_in(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      tick();
      cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         cnt += int'(pipe_read);
         tick();
      end
      check("ws_old_issues", 64'(cnt), 64'd3);
      set_in(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      tick();
      check("ws_first_pr", 64'(pipe_read), 64'h1);
      check("ws_first_nonce", 64'(pin_nonce(pipe_in)), 64'h100);
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
         tick();
         check($sformatf("ws_drop%0d", k), 64'(found_valid), 64'h0);
      end
      set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("ws_win_valid", 64'(found_valid), 64'h1);
      check("ws_win_nonce", 64'(found_nonce), 64'h100);

      // In-flight limit on the MAX_INFLIGHT=2 instance
      do_reset();
      set_in(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         cnt += int'(l_pipe_read);
         tick();
      end
      check("lim_issues", 64'(cnt), 64'd2);
      check("lim_busy", 64'(l_busy), 64'h1);
      l_pipe_write = 1'b1;
      tick();
      l_pipe_write = 1'b0;
      check("lim_third_pr", 64'(l_pipe_read), 64'h1);
      check("lim_third_nonce", 64'(pin_nonce(l_pipe_in)), 64'h2);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         cnt += int'(l_pipe_read);
      end
      check("lim_blocked_again", 64'(cnt), 64'd0);

      // Nonce-space exhaustion
      do_reset();
      set_in(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      tick();
      cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         cnt += int'(pipe_read);
         tick();
      end
      check("ex_issues", 64'(cnt), 64'd2);
      check("ex_exhausted", 64'(exhausted), 64'h1);
      check("ex_busy", 64'(busy), 64'h0);
      set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("ex_win0_valid", 64'(found_valid), 64'h1);
      check("ex_win0_nonce", 64'(found_nonce), 64'hFFFF_FFFE);
      tick();
      check("ex_win1_nonce", 64'(found_nonce), 64'hFFFF_FFFF);
      tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("ex_drained", 64'(found_valid), 64'h0);
      check("ex_no_issue", 64'(pipe_read), 64'h0);

      // FIFO overflow, then a new load keeps entries and clears the flag
      do_reset();
      set_in(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 17; k++) begin
         set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
         if (k == 4) check("ovf_before", 64'(found_overflow), 64'h0);
         tick();
      end
      check("ovf_set", 64'(found_overflow), 64'h1);
      check("ovf_head", 64'(found_nonce), 64'h200);
      set_in(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
      tick();
      check("ovf_cleared", 64'(found_overflow), 64'h0);
      for (int k = 0; k < 4; k++) begin
         set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
         check($sformatf("ovf_pop%0d_valid", k), 64'(found_valid), 64'h1);
         check($sformatf("ovf_pop%0d_nonce", k), 64'(found_nonce), 64'(32'h200 + 32'(k)));
         tick();
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("ovf_empty", 64'(found_valid), 64'h0);

      // Reset mid-run with 5 outstanding and one queued winner
      do_reset();
      set_in(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 21; k++) begin
         set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("mr_pre_valid", 64'(found_valid), 64'h1);
      check("mr_pre_nonce", 64'(found_nonce), 64'h500);
      rst_n = 1'b0;
      #1;
      check("mr_pipe_read", 64'(pipe_read), 64'h0);
      check("mr_found_valid", 64'(found_valid), 64'h0);
      check("mr_busy", 64'(busy), 64'h0);
      check("mr_pipe_in_zero", 64'(pipe_in == '0), 64'h1);
      check("mr_target_zero", 64'(pipe_target == '0), 64'h1);
      check("mr_found_nonce", 64'(found_nonce), 64'h0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
         tick();
         check($sformatf("mr_stray%0d_valid", k), 64'(found_valid), 64'h0);
         check($sformatf("mr_stray%0d_pr", k), 64'(pipe_read), 64'h0);
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/odo_work_sched.md
# odo_work_sched

Work scheduler between the host-facing source/probe registers and one `odo_keccak` hashing pipeline. It latches new work (header, target, start nonce) and issues one nonce to the pipeline every `THROUGHPUT` cycles. It tracks in-flight hashes so that results belonging to superseded work are discarded, and it queues winning nonces in a small FIFO for the host to read. It replaces free-running nonce counting with explicit work epochs, in-flight limiting and nonce-space exhaustion handling.

## Interface
- `THROUGHPUT`, 8: cycles between successive pipeline issues; legal range 1..64.
- `MAX_INFLIGHT`, 255: maximum number of outstanding (issued, not yet returned) hashes; sets the width of the outstanding counter.
- `FIFO_DEPTH`, 4: number of entries in the found-nonce FIFO; power of two.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `work_load` in 1: one-cycle pulse that latches new work.
- `work_header` in 608: block header, sampled on `work_load`.
- `work_target` in 256: target, sampled on `work_load`.
- `work_nonce` in 32: start nonce, sampled on `work_load`.
- `pipe_in` out 640: `{nonce, header}` presented to the pipeline.
- `pipe_read` out 1: issue strobe to the pipeline.
- `pipe_target` out 256: latched target.
- `pipe_res` in 1: comparison result from the pipeline.
- `pipe_write` in 1: result-valid strobe from the pipeline; results return in issue order.
- `found_valid` out 1: FIFO non-empty.
- `found_nonce` out 32: FIFO head.
- `found_ready` in 1: pop the FIFO head when `found_valid` is high.
- `found_overflow` out 1: sticky; set when a winner was dropped because the FIFO was full.
- `busy` out 1: high in RUN.
- `exhausted` out 1: high in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE:** no issues.
- **RUN:** slot counter counts 0..`THROUGHPUT`-1. At slot 0, `pipe_read` pulses if `outstanding < MAX_INFLIGHT`. Otherwise the slot is skipped and the counter holds at 0 until room exists.
- **Issue:** drive `pipe_in = {issue_nonce, header}`, then increment `issue_nonce`. Issuing nonce 0xFFFFFFFF moves to DONE (no wrap).
- **DONE:** no issues. Results still drain.
- **`work_load` from any state:**
  - latch header, target and `work_nonce` into `issue_nonce` and `ret_nonce`;
  - set `discard = outstanding` (counted after this cycle's issue/return);
  - clear `found_overflow`; do not flush the FIFO;
  - go to RUN with slot counter 0.
- **`outstanding`:** +1 per issue, −1 per `pipe_write`. Both in one cycle means no change.
- **On `pipe_write`:**
  - if `discard > 0`: decrement `discard`, drop the result, leave `ret_nonce` unchanged;
  - otherwise: if `pipe_res`, push `ret_nonce` into the FIFO; increment `ret_nonce` either way.
- A `pipe_write` in the same cycle as `work_load` belongs to the old epoch and is always dropped.
- **FIFO full:** a push is dropped and `found_overflow` is set. Push and pop in the same cycle while full: the pop frees the slot and the push succeeds.
- **Width rules:** nonce arithmetic is mod 2^32. `outstanding` and `discard` use $clog2(`MAX_INFLIGHT`+1) bits and never underflow. A `pipe_write` with `outstanding == 0` is a protocol error: ignore it and leave the counters unchanged.

## Timing
- **Reset values:** `pipe_read`, `found_valid`, `found_overflow`, `busy` and `exhausted` are 0. `pipe_in`, `pipe_target` and `found_nonce` are 0.
- **Issue latency:** `work_load` at cycle N gives the first `pipe_read` at N+1 with nonce `work_nonce`. The next issue is at N+1+`THROUGHPUT`.
- `pipe_in` and `pipe_target` are registered and stable from the `pipe_read` cycle until the next issue.
- **Result latency:** winning `pipe_write` at cycle M gives `found_valid` at M+1. `found_nonce` is the registered FIFO head.
- **Pop:** `found_valid && found_ready` at cycle K presents the next entry (or deasserts `found_valid`) at K+1.
- **`rst_n` mid-operation:** everything clears immediately. In-flight pipeline results arriving after reset are counted against `outstanding == 0` and therefore ignored.

## Structure
- Package `odo_sched_pkg`: state enum (IDLE/RUN/DONE), nonce width 32, header width 608, target width 256.
- Sub-module `found_fifo`: synchronous FIFO with parameters width and depth, full/empty flags, asynchronous active-low reset.
- The scheduler FSM, slot counter and in-flight/discard counters live in `odo_work_sched`.

## Test plan
- **Basic issue:** `THROUGHPUT`=4, load `work_nonce`=0x10 → `pipe_read` at cycles 1,5,9 with nonces 0x10,0x11,0x12. Model returns `pipe_res`=1 on the second result → `found_nonce`=0x11.
- **Work switch:** 3 outstanding, load `work_nonce`=0x100 → next 3 `pipe_write` are dropped even when `pipe_res`=1. The 4th result with `pipe_res`=1 → `found_nonce`=0x100.
- **In-flight limit:** `MAX_INFLIGHT`=2 with no returns → exactly 2 issues, then `pipe_read` stays low. One `pipe_write` → a third issue on the following slot-0.
- **Exhaustion:** load 0xFFFFFFFE → 2 issues, `exhausted`=1, no further `pipe_read`. Winners still enter the FIFO as 0xFFFFFFFE/0xFFFFFFFF.
- **FIFO overflow:** `FIFO_DEPTH`=4, 5 winners with `found_ready`=0 → 4 entries held, `found_overflow`=1. Next `work_load` clears the flag and keeps the entries.
- **Reset mid-run:** assert `rst_n` low with outstanding=5 → all outputs return to reset values, and subsequent stray `pipe_write` causes no FIFO push.
